// File: rtl/number_entry_ctrl.sv
// PS/2 set-2 keyboard front end that assembles a packed-BCD operand and commits it to regNumber.
// Optional keypad digit decoding is enabled with the NUMPAD_EN macro.
module number_entry_ctrl #(
    parameter int unsigned DIGITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        code_valid,
    input  logic [7:0]  code,
    output logic [31:0] x,
    output logic        flag,
    output logic [31:0] entry,
    output logic [3:0]  count,
    output logic        err
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned COUNT_W = 4;
    localparam int unsigned ENTRY_W = 4 * DIGITS;

    localparam logic [DATA_W-1:0]  ENTRY_MASK = DATA_W'((33'd1 << ENTRY_W) - 33'd1);
    localparam logic [COUNT_W-1:0] COUNT_MAX  = COUNT_W'(DIGITS);

    localparam logic [7:0] BYTE_BREAK = 8'hF0;
    localparam logic [7:0] BYTE_EXT   = 8'hE0;
    localparam logic [7:0] KEY_ENTER  = 8'h5A;
    localparam logic [7:0] KEY_BKSP   = 8'h66;
    localparam logic [7:0] KEY_ESC    = 8'h76;

    typedef enum logic [1:0] {
        IDLE,
        BREAK,
        EXT,
        EXT_BREAK
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   entry_q, entry_d;
    logic [DATA_W-1:0]   x_q, x_d;
    logic [COUNT_W-1:0]  count_q, count_d;
    logic                flag_q, flag_d;
    logic                err_q, err_d;

    logic                release_key;
    logic                commit;
    logic [4:0]          dig;

    // Returns {is_digit, bcd_value} for a released key's scan code.
    function automatic logic [4:0] decode_digit(input logic [7:0] b);
        logic [4:0] r;
        r = 5'h00;
        case (b)
            8'h45: r = 5'h10;
            8'h16: r = 5'h11;
            8'h1E: r = 5'h12;
            8'h26: r = 5'h13;
            8'h25: r = 5'h14;
            8'h2E: r = 5'h15;
            8'h36: r = 5'h16;
            8'h3D: r = 5'h17;
            8'h3E: r = 5'h18;
            8'h46: r = 5'h19;
`ifdef NUMPAD_EN
            8'h70: r = 5'h10;
            8'h69: r = 5'h11;
            8'h72: r = 5'h12;
            8'h7A: r = 5'h13;
            8'h6B: r = 5'h14;
            8'h73: r = 5'h15;
            8'h74: r = 5'h16;
            8'h6C: r = 5'h17;
            8'h75: r = 5'h18;
            8'h7D: r = 5'h19;
`else
`endif
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            entry_q <= '0;
            x_q     <= '0;
            count_q <= '0;
            flag_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            x_q     <= x_d;
            count_q <= count_d;
            flag_q  <= flag_d;
            err_q   <= err_d;
        end
    end

    // Prefix tracking, key actions and commit.
    always_comb begin
        state_d     = state_q;
        entry_d     = entry_q;
        x_d         = x_q;
        count_d     = count_q;
        flag_d      = 1'b0;
        err_d       = 1'b0;
        release_key = 1'b0;
        commit      = 1'b0;
        dig         = decode_digit(code);

        if (code_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (code == BYTE_BREAK) begin
                        state_d = BREAK;
                    end else if (code == BYTE_EXT) begin
                        state_d = EXT;
                    end
                end
                BREAK: begin
                    if (code == BYTE_BREAK) begin
                        state_d = BREAK;
                    end else if (code == BYTE_EXT) begin
                        state_d = EXT;
                    end else begin
                        release_key = 1'b1;
                        state_d     = IDLE;
                    end
                end
                EXT: begin
                    state_d = (code == BYTE_BREAK) ? EXT_BREAK : IDLE;
                end
                EXT_BREAK: begin
                    state_d = IDLE;
                    commit  = (code == KEY_ENTER);
                end
                default: state_d = IDLE;
            endcase
        end

        if (release_key) begin
            if (dig[4]) begin
                if (count_q >= COUNT_MAX) begin
                    err_d = 1'b1;
                end else if (!(count_q == '0 && dig[3:0] == 4'h0)) begin
                    entry_d = ENTRY_MASK & {entry_q[DATA_W-5:0], dig[3:0]};
                    count_d = count_q + COUNT_W'(1);
                end
            end else if (code == KEY_BKSP) begin
                if (count_q != '0) begin
                    entry_d = entry_q >> 4;
                    count_d = count_q - COUNT_W'(1);
                end
            end else if (code == KEY_ESC) begin
                entry_d = '0;
                count_d = '0;
            end else if (code == KEY_ENTER) begin
                commit = 1'b1;
            end
        end

        if (commit) begin
            x_d     = entry_q;
            flag_d  = 1'b1;
            entry_d = '0;
            count_d = '0;
        end
    end

    assign x     = x_q;
    assign flag  = flag_q;
    assign entry = entry_q;
    assign count = count_q;
    assign err   = err_q;

endmodule
